// File: rtl/ddr_addr_mapper.sv
// rtl/ddr_addr_mapper.sv - byte address to DDR col/bank/row mapper with open-row classification
module ddr_addr_mapper #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int BO_W     = 3,
  parameter int COL_W    = 10,
  parameter int BANK_W   = 3,
  parameter int ROW_W    = 14,
  parameter int BANK_XOR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              map_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_write,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_write,
  output logic [DATA_W-1:0] out_wdata,
  output logic [COL_W-1:0]  out_col,
  output logic [BANK_W-1:0] out_bank,
  output logic [ROW_W-1:0]  out_row,
  output logic [1:0]        out_cls,
  input  logic              pre_valid,
  input  logic              pre_all,
  input  logic [BANK_W-1:0] pre_bank
);

  localparam int USED_W = BO_W + COL_W + BANK_W + ROW_W;
  localparam int NB     = 1 << BANK_W;
  localparam int EXT_W  = (ROW_W > BANK_W) ? ROW_W : BANK_W;

  if (ADDR_W < USED_W) begin : g_addr_w_check
    $error("ddr_addr_mapper: ADDR_W smaller than BO_W+COL_W+BANK_W+ROW_W");
  end

  logic              mode_q;
  logic [NB-1:0]     open_q;
  logic [ROW_W-1:0]  row_q [NB];

  logic              accept;
  logic              mode_chg;
  logic              addr_err;
  logic [COL_W-1:0]  col_d;
  logic [BANK_W-1:0] bank_raw;
  logic [BANK_W-1:0] bank_d;
  logic [ROW_W-1:0]  row_d;
  logic [EXT_W-1:0]  row_ext;
  logic [1:0]        cls_d;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign mode_chg = (map_mode != mode_q);
  assign addr_err = ((in_addr >> USED_W) != '0);

  // Decode always uses the live map_mode so a mode-switch request maps with the new layout.
  always_comb begin
    col_d    = in_addr[BO_W +: COL_W];
    row_d    = '0;
    bank_raw = '0;
    if (map_mode) begin
      row_d    = in_addr[BO_W+COL_W +: ROW_W];
      bank_raw = in_addr[BO_W+COL_W+ROW_W +: BANK_W];
    end else begin
      bank_raw = in_addr[BO_W+COL_W +: BANK_W];
      row_d    = in_addr[BO_W+COL_W+BANK_W +: ROW_W];
    end
    row_ext = EXT_W'(row_d);
    bank_d  = (BANK_XOR != 0) ? (bank_raw ^ row_ext[BANK_W-1:0]) : bank_raw;
  end

  always_comb begin
    cls_d = 2'b00;
    if (addr_err) begin
      cls_d = 2'b11;
    end else if (mode_chg || !open_q[bank_d]) begin
      cls_d = 2'b00;
    end else if (row_q[bank_d] == row_d) begin
      cls_d = 2'b01;
    end else begin
      cls_d = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_write <= 1'b0;
      out_wdata <= '0;
      out_col   <= '0;
      out_bank  <= '0;
      out_row   <= '0;
      out_cls   <= 2'b00;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_write <= in_write;
      out_wdata <= in_wdata;
      out_col   <= col_d;
      out_bank  <= bank_d;
      out_row   <= row_d;
      out_cls   <= cls_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Closes are issued first so the request's open (later assignment) wins on the same bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      open_q <= '0;
      for (int b = 0; b < NB; b++) begin
        row_q[b] <= '0;
      end
    end else begin
      mode_q <= map_mode;
      for (int b = 0; b < NB; b++) begin
        if (mode_chg || (pre_valid && (pre_all || (pre_bank == BANK_W'(b))))) begin
          open_q[b] <= 1'b0;
        end
      end
      if (accept && !addr_err) begin
        open_q[bank_d] <= 1'b1;
        row_q[bank_d]  <= row_d;
      end
    end
  end

endmodule

// File: tb/tb_ddr_addr_mapper.sv
// tb/tb_ddr_addr_mapper.sv - directed table plus randomized model-checked bench for ddr_addr_mapper
module tb_ddr_addr_mapper;

  localparam int NB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        map_mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic        in_write = 1'b0;
  logic [31:0] in_wdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_write;
  logic [31:0] out_wdata;
  logic [9:0]  out_col;
  logic [2:0]  out_bank;
  logic [13:0] out_row;
  logic [1:0]  out_cls;
  logic        pre_valid = 1'b0;
  logic        pre_all = 1'b0;
  logic [2:0]  pre_bank = '0;

  ddr_addr_mapper dut (
    .clk(clk), .rst_n(rst_n), .map_mode(map_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_write(in_write), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_write(out_write),
    .out_wdata(out_wdata), .out_col(out_col), .out_bank(out_bank),
    .out_row(out_row), .out_cls(out_cls),
    .pre_valid(pre_valid), .pre_all(pre_all), .pre_bank(pre_bank)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: open-row table and expected output register.
  bit          m_open [NB];
  int          m_row  [NB];
  bit          m_mode;
  bit          m_valid;
  int          e_col, e_bank, e_row, e_cls;
  bit          e_write;
  logic [31:0] e_wdata;

  typedef struct {
    logic [31:0] addr;
    bit          mode;
    bit          rdy;
    bit          pv;
    int          col;
    int          bank;
    int          row;
    int          cls;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      m_open[i] = 1'b0;
      m_row[i]  = 0;
    end
    m_mode  = 1'b0;
    m_valid = 1'b0;
  endfunction

  function automatic void decode(input logic [31:0] a, input bit mode,
                                 output int col, output int bank, output int row, output bit err);
    longint ua;
    ua  = longint'({32'd0, a});
    col = int'((ua / 8) % 1024);
    if (!mode) begin
      bank = int'((ua / 8192) % 8);
      row  = int'((ua / 65536) % 16384);
    end else begin
      row  = int'((ua / 8192) % 16384);
      bank = int'((ua / 134217728) % 8);
    end
    err = (ua >= 64'd1073741824);
  endfunction

  task automatic step(input bit v, input logic [31:0] a, input bit w, input logic [31:0] d,
                      input bit mode, input bit rdy, input bit pv, input bit pa, input logic [2:0] pb);
    bit acc;
    bit err;
    int col, bank, row;
    err = 1'b0;
    bank = 0;
    row = 0;
    @(negedge clk);
    in_valid = v; in_addr = a; in_write = w; in_wdata = d; map_mode = mode;
    out_ready = rdy; pre_valid = pv; pre_all = pa; pre_bank = pb;
    #1;
    chk("in_ready", 64'(in_ready), 64'(!m_valid || rdy));
    acc = v && (!m_valid || rdy);
    if (acc) begin
      decode(a, mode, col, bank, row, err);
      e_col = col; e_bank = bank; e_row = row; e_write = w; e_wdata = d;
      if (err) e_cls = 3;
      else if (mode != m_mode || !m_open[bank]) e_cls = 0;
      else if (m_row[bank] == row) e_cls = 1;
      else e_cls = 2;
      m_valid = 1'b1;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < NB; i++) begin
      if (mode != m_mode || (pv && (pa || i == int'(pb)))) m_open[i] = 1'b0;
    end
    if (acc && !err) begin
      m_open[bank] = 1'b1;
      m_row[bank]  = row;
    end
    m_mode = mode;
    @(posedge clk);
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      chk("out_col", 64'(out_col), 64'(e_col));
      chk("out_bank", 64'(out_bank), 64'(e_bank));
      chk("out_row", 64'(out_row), 64'(e_row));
      chk("out_cls", 64'(out_cls), 64'(e_cls));
      chk("out_write", 64'(out_write), 64'(e_write));
      chk("out_wdata", 64'(out_wdata), 64'(e_wdata));
    end
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    bit          mode_r, v, w, rdy, pv, pa;
    logic [2:0]  pb;

    // col, bank, row, cls are the values the spec examples require
    vt.push_back('{32'h0000_1238, 1'b0, 1'b1, 1'b0, 'h247, 0, 0, 0});
    vt.push_back('{32'h0000_1238, 1'b0, 1'b1, 1'b0, 'h247, 0, 0, 1});
    vt.push_back('{32'h0001_0000, 1'b0, 1'b1, 1'b0, 0, 0, 1, 2});
    vt.push_back('{32'h0000_1238, 1'b0, 1'b1, 1'b0, 'h247, 0, 0, 2});
    vt.push_back('{32'h8000_0000, 1'b0, 1'b1, 1'b0, 0, 0, 0, 3});
    vt.push_back('{32'h0000_0000, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1});
    vt.push_back('{32'h0000_0000, 1'b0, 1'b1, 1'b1, 0, 0, 0, 1});
    vt.push_back('{32'h0000_0000, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1});
    vt.push_back('{32'h0000_1238, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1});
    vt.push_back('{32'h0000_1238, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1});
    vt.push_back('{32'h0000_1238, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1});
    vt.push_back('{32'h0000_2000, 1'b1, 1'b1, 1'b0, 0, 0, 1, 0});

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_fields", 64'({out_col, out_bank, out_row, out_cls, out_write}), 64'(0));
    chk("rst_out_wdata", 64'(out_wdata), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      step(1'b1, vt[i].addr, 1'b0, $urandom, vt[i].mode, vt[i].rdy, vt[i].pv, 1'b0, 3'd0);
      chk($sformatf("tbl%0d_col", i), 64'(out_col), 64'(vt[i].col));
      chk($sformatf("tbl%0d_bank", i), 64'(out_bank), 64'(vt[i].bank));
      chk($sformatf("tbl%0d_row", i), 64'(out_row), 64'(vt[i].row));
      chk($sformatf("tbl%0d_cls", i), 64'(out_cls), 64'(vt[i].cls));
    end

    mode_r = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 99) < 3) mode_r = !mode_r;
      if (r < 5) a = $urandom;
      else if (r < 10) a = 32'h4000_0000 | ($urandom & 32'h0003_ffff);
      else if (mode_r) a = $urandom & 32'h3800_7fff;
      else a = $urandom & 32'h0003_ffff;
      v   = ($urandom_range(0, 3) != 0);
      w   = ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 3) != 0);
      pv  = ($urandom_range(0, 9) == 0);
      pa  = ($urandom_range(0, 2) == 0);
      pb  = 3'($urandom_range(0, 7));
      step(v, a, w, $urandom, mode_r, rdy, pv, pa, pb);
    end

    // Asynchronous reset while a stalled request is held on the output.
    step(1'b1, 32'h0000_1238, 1'b1, 32'hdead_beef, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'(0));
    chk("async_rst_in_ready", 64'(in_ready), 64'(1));
    chk("async_rst_out_cls", 64'(out_cls), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h0000_1238, 1'b0, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    chk("post_rst_cls", 64'(out_cls), 64'(0));
    step(1'b1, 32'h0000_1238, 1'b0, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    chk("post_rst_hit", 64'(out_cls), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
